// File: rtl/core_pkg.sv
// Shared types and default widths for the core's memory-port arbiter.
package core_pkg;

    localparam int unsigned ARB_AW = 32;
    localparam int unsigned ARB_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and LSU requests.
// ARB_ROUND_ROBIN_EN selects alternating priority; otherwise LSU always beats IF.
module arb_pick
    import core_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic [1:0] gnt
);

    // gnt[0] = IF wins, gnt[1] = LSU wins
    always_comb begin
        gnt = '0;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && d_req) begin
            gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
        end else begin
            gnt = {d_req, if_req};
        end
`else
        if (d_req) begin
            gnt = 2'b10;
        end else begin
            gnt = {1'b0, if_req};
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_be_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_owner;
    logic [1:0] pick;
    logic       idle;
    logic       rsp_done;

    arb_pick u_pick (
        .if_req     (if_req_i),
        .d_req      (d_req_i),
        .last_owner (last_owner),
        .gnt        (pick)
    );

    // Grants are combinational so an IDLE request is accepted in the same cycle.
    assign idle     = (state == ARB_IDLE) && !rst_i;
    assign if_gnt_o = idle && pick[0];
    assign d_gnt_o  = idle && pick[1];

    // A response only counts once the request has been accepted.
    assign rsp_done = mem_rvalid_i &&
                      (((state == ARB_REQ) && mem_ready_i) || (state == ARB_RSP));

`ifndef ARB_ROUND_ROBIN_EN
    assign last_owner = OWN_IF;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ARB_IDLE;
            owner       <= OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= OWN_IF;
`endif
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;

            if (rsp_done) begin
                if (owner == OWN_D) begin
                    d_rdata_o  <= mem_rdata_i;
                    d_rvalid_o <= 1'b1;
                end else begin
                    if_rdata_o  <= mem_rdata_i;
                    if_rvalid_o <= 1'b1;
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (d_gnt_o) begin
                        owner       <= OWN_D;
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        mem_be_o    <= d_we_i ? d_be_i : '1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner  <= OWN_D;
`endif
                        state       <= ARB_REQ;
                    end else if (if_gnt_o) begin
                        owner       <= OWN_IF;
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        mem_be_o    <= '1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner  <= OWN_IF;
`endif
                        state       <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= mem_rvalid_i ? ARB_IDLE : ARB_RSP;
                    end
                end
                ARB_RSP: begin
                    if (mem_rvalid_i) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_be_i       (d_be_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick;
        tick;
        #1;
        n_checks++;
        if ({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_valid_o, mem_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_valid_o, mem_we_o});
        end
        n_checks++;
        if ({mem_addr_o, mem_wdata_o, mem_be_o, if_rdata_o, d_rdata_o} !== 132'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0",
                     {mem_addr_o, mem_wdata_o, mem_be_o, if_rdata_o, d_rdata_o});
        end
        tick;
        rst_i = 1'b0;
    endtask

    task automatic test_if_only;
        tick;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0010;
        #1;
        n_checks++;
        if ({if_gnt_o, d_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL if_gnt: got %b required 10", {if_gnt_o, d_gnt_o});
        end
        tick;
        if_req_i     = 1'b0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0050_0093;
        #1;
        n_checks++;
        if ({mem_valid_o, mem_we_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
            n_fail++;
            $display("FAIL if_mem_req: got %h required %h",
                     {mem_valid_o, mem_we_o, mem_addr_o, mem_be_o}, {1'b1, 1'b0, 32'h10, 4'hF});
        end
        tick;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, d_rvalid_o, mem_valid_o, if_rdata_o} !== {3'b100, 32'h0050_0093}) begin
            n_fail++;
            $display("FAIL if_rsp: got %h required %h",
                     {if_rvalid_o, d_rvalid_o, mem_valid_o, if_rdata_o}, {3'b100, 32'h0050_0093});
        end
        tick;
        #1;
        n_checks++;
        if (if_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL if_rvalid_pulse: got %b required 0", if_rvalid_o);
        end
    endtask

    task automatic test_store;
        tick;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_0100;
        d_wdata_i = 32'hDEAD_BEEF;
        d_be_i    = 4'h3;
        #1;
        n_checks++;
        if ({d_gnt_o, if_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_gnt: got %b required 10", {d_gnt_o, if_gnt_o});
        end
        tick;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = 32'hFFFF_FFFF;
        d_wdata_i = 32'h0;
        d_be_i    = 4'hC;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready_i = 1'b1;
            #1;
            n_checks++;
            if ({mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !==
                {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3}) begin
                n_fail++;
                $display("FAIL st_hold[%0d]: got %h required %h", i,
                         {mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                         {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3});
            end
            tick;
        end
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid_o, d_rvalid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL st_wait: got %b required 00", {mem_valid_o, d_rvalid_o});
        end
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({d_rvalid_o, if_rvalid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_ack: got %b required 10", {d_rvalid_o, if_rvalid_o});
        end
        tick;
        #1;
        n_checks++;
        if (d_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL st_ack_pulse: got %b required 0", d_rvalid_o);
        end
    endtask

    task automatic test_simultaneous;
        tick;
        rst_i = 1'b1;
        tick;
        rst_i     = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0020;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h0000_0200;
        d_be_i    = 4'h0;
        #1;
        n_checks++;
        if ({d_gnt_o, if_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL sim_first: got %b required 10", {d_gnt_o, if_gnt_o});
        end
        tick;
        d_req_i     = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt_o, mem_valid_o, mem_we_o, mem_addr_o, mem_be_o} !==
            {3'b010, 32'h200, 4'hF}) begin
            n_fail++;
            $display("FAIL sim_load_req: got %h required %h",
                     {if_gnt_o, mem_valid_o, mem_we_o, mem_addr_o, mem_be_o}, {3'b010, 32'h200, 4'hF});
        end
        tick;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1122_3344;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_no_gnt_rsp: got %b required 0", if_gnt_o);
        end
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({d_rvalid_o, d_rdata_o, if_rvalid_o, if_gnt_o} !== {1'b1, 32'h1122_3344, 2'b01}) begin
            n_fail++;
            $display("FAIL sim_second: got %h required %h",
                     {d_rvalid_o, d_rdata_o, if_rvalid_o, if_gnt_o}, {1'b1, 32'h1122_3344, 2'b01});
        end
        tick;
        if_req_i     = 1'b0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0013;
        #1;
        n_checks++;
        if ({mem_valid_o, mem_addr_o} !== {1'b1, 32'h20}) begin
            n_fail++;
            $display("FAIL sim_if_req: got %h required %h", {mem_valid_o, mem_addr_o}, {1'b1, 32'h20});
        end
        tick;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, d_rvalid_o, if_rdata_o} !== {2'b10, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL sim_if_rsp: got %h required %h",
                     {if_rvalid_o, d_rvalid_o, if_rdata_o}, {2'b10, 32'h0000_0013});
        end
    endtask

    task automatic test_arb_sequence;
        logic [3:0] order;
        logic [3:0] exp_order;
        int         n;
        int         budget;
        order  = '0;
        n      = 0;
        budget = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        tick;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0030;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h0000_0300;
        while (n < 4 && budget < 40) begin
            #1;
            mem_ready_i  = mem_valid_o;
            mem_rvalid_i = mem_valid_o;
            if (d_gnt_o || if_gnt_o) begin
                n_checks++;
                if (d_gnt_o && if_gnt_o) begin
                    n_fail++;
                    $display("FAIL seq_onehot[%0d]: got 11 required one grant", n);
                end
                order[n] = d_gnt_o;
                n++;
            end
            tick;
            budget++;
        end
        if_req_i     = 1'b0;
        d_req_i      = 1'b0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        tick;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL seq_count: got %0d grants required 4", n);
        end
        n_checks++;
        if (order !== exp_order) begin
            n_fail++;
            $display("FAIL seq_order: got %b required %b (bit i = grant i, 1 = LSU)", order, exp_order);
        end
    endtask

    task automatic test_spurious;
        tick;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_0001;
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, d_rvalid_o, mem_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL spur_idle: got %b required 000", {if_rvalid_o, d_rvalid_o, mem_valid_o});
        end
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0050;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_still_idle: got %b required 1", if_gnt_o);
        end
        tick;
        if_req_i     = 1'b0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, d_rvalid_o, mem_valid_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL spur_req: got %b required 001", {if_rvalid_o, d_rvalid_o, mem_valid_o});
        end
        mem_ready_i = 1'b1;
        tick;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_0001;
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL spur_real_rsp: got %h required %h", {if_rvalid_o, if_rdata_o}, {1'b1, 32'hCAFE_0001});
        end
    endtask

    task automatic test_reset_mid_txn;
        tick;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0040;
        tick;
        if_req_i    = 1'b0;
        mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0;
        rst_i       = 1'b1;
        if_req_i    = 1'b1;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_gnt: got %b required 0", if_gnt_o);
        end
        tick;
        tick;
        rst_i        = 1'b0;
        if_req_i     = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if ({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_valid_o, mem_we_o, mem_addr_o,
             mem_wdata_o, mem_be_o, if_rdata_o, d_rdata_o} !== 138'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h required 0",
                     {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_valid_o, mem_we_o, mem_addr_o,
                      mem_wdata_o, mem_be_o, if_rdata_o, d_rdata_o});
        end
        tick;
        mem_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({if_rvalid_o, d_rvalid_o, if_rdata_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_late_rsp: got %h required 0", {if_rvalid_o, d_rvalid_o, if_rdata_o});
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        d_be_i       = '0;
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        test_reset;
        test_if_only;
        test_store;
        test_simultaneous;
        test_arb_sequence;
        test_spurious;
        test_reset_mid_txn;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
